amt_recovery_sequencer: RTL and testbench
=========================================

// Module: amt_recovery_sequencer
// PURPOSE
//  Sequences the Architectural Map Table walk after an exception/branch-mispredict recovery.
//  Stalls commit, drains in-flight AMT writes, then steps the AMT read base through all logical
//  regs, WALK_WIDTH per cycle, under an RMT ready handshake. Sits between ActiveList and AMT/RMT.
//  Replaces the free-running recover counter with a flow-controlled FSM and a completion signal.
// PARAMETERS
//  NUM_LOG_REGS  32  logical regs held in AMT/RMT; must be a multiple of WALK_WIDTH
//  LOG_REG_W     5   log2(NUM_LOG_REGS)
//  WALK_WIDTH    4   AMT entries sent to RMT per beat (= AMT read ports = RMT write ports)
//  DRAIN_MAX     7   max cycles in DRAIN before forcing WALK; must fit in 3 bits
// PORTS
//  clk             in   1          clock
//  reset           in   1          asynchronous, active-high reset
//  recoverReq_i    in   1          1-cycle pulse from ActiveList: recovery required
//  commitBusy_i    in   1          AMT write pipe holds an in-flight commit write
//  rmtReady_i      in   1          RMT accepts the current recover beat this cycle
//  commitStall_o   out  1          blocks ActiveList retirement into AMT
//  recoverValid_o  out  1          recover beat valid; AMT read base on amtBase_o
//  amtBase_o       out  LOG_REG_W  AMT read address for port 0; port k reads amtBase_o+k
//  recoverLast_o   out  1          current beat is the final one (base = NUM_LOG_REGS-WALK_WIDTH)
//  recoverDone_o   out  1          1-cycle pulse: RMT fully restored, front end may restart
//  recoverBusy_o   out  1          high from accepted request until the done pulse
// BEHAVIOUR
//  - Reset (async assert): state=IDLE, all outputs 0, amtBase_o=0, drain counter=0.
//  - FSM: IDLE -> DRAIN -> WALK -> DONE -> IDLE.
//  - IDLE: recoverReq_i=1 -> DRAIN next cycle; commitStall_o, recoverBusy_o go high that edge.
//  - DRAIN: commitStall_o=1. Leave for WALK when commitBusy_i=0 or drain count reaches DRAIN_MAX.
//    Counter clears on entry. The DRAIN_MAX exit asserts a sim-only error (AMT write lost).
//  - WALK: recoverValid_o=1, commitStall_o=1. Beat accepted when recoverValid_o & rmtReady_i.
//    On accept, amtBase_o += WALK_WIDTH. With rmtReady_i=0, amtBase_o and beat hold stable.
//    amtBase_o is never used for the write side; AMT write addrs stay commit-driven.
//  - Last beat accepted -> DONE; amtBase_o wraps to 0 in LOG_REG_W bits; recoverValid_o drops.
//  - DONE: one cycle. recoverDone_o=1 and commitStall_o=1; then IDLE, stall and busy drop.
//  - Minimum latency, request to done: 1 (DRAIN) + NUM_LOG_REGS/WALK_WIDTH (WALK) + 1 (DONE)
//    = 10 cycles at defaults with rmtReady_i tied high.
//  - recoverReq_i in DRAIN/WALK/DONE: ignored. The AMT is frozen by the stall, so one walk suffices.
//  - recoverReq_i the same cycle as the done pulse: ignored. The ActiveList holds no new requests
//    until it has seen recoverDone_o.
//  - Async reset mid-walk: immediate return to IDLE; the partial RMT restore is discarded by upstream reset.
//  - Packet index arithmetic is modulo 2^LOG_REG_W. amtBase_o+k never overflows when
//    NUM_LOG_REGS is a multiple of WALK_WIDTH (elaboration check).
// CONFIGURATION
//  - AMT_RECOVER_PERF_EN defined: adds output recoverCycles_o [15:0].
//    It counts cycles with recoverBusy_o=1 and saturates at 16'hFFFF.
//    The count is cleared only by reset, for performance counters.
//  - Undefined: no counter, no port. FSM timing is identical in both builds.
// STRUCTURE
//  - Shared package/header: state encoding localparams (IDLE=2'd0, DRAIN=2'd1, WALK=2'd2,
//    DONE=2'd3), NUM_LOG_REGS/LOG_REG_W/WALK_WIDTH defaults tied to SIZE_RMT/SIZE_RMT_LOG.
//  - No sub-module; one FSM block plus the base counter (and the optional perf counter) in one file.
// TESTING
//  1. Reset, pulse recoverReq_i, commitBusy_i=0, rmtReady_i=1 -> amtBase_o 0,4,...,28 on
//     8 consecutive beats. recoverLast_o only at 28; recoverDone_o 10 cycles after the request.
//  2. commitBusy_i=1 for 3 cycles after the request -> DRAIN lasts 3 cycles, WALK starts on the 4th;
//     commitBusy_i stuck 1 -> WALK forced after 7 cycles and the error fires.
//  3. rmtReady_i toggling 1,0,0,1 during WALK -> amtBase_o/recoverValid_o hold while not ready;
//     exactly 8 accepted beats, no base skipped or repeated.
//  4. Second recoverReq_i pulse mid-WALK -> ignored; exactly one recoverDone_o pulse.
//  5. Async reset asserted at beat 4 -> all outputs 0 the same cycle. A fresh request then walks from base 0.
//  6. With AMT_RECOVER_PERF_EN, two back-to-back recoveries at full ready -> recoverCycles_o=20.

Source files
------------

// File: rtl/amt_recovery_sequencer_pkg.sv
// Shared sizing defaults and FSM state encoding for the AMT recovery sequencer.
package amt_recovery_sequencer_pkg;

    localparam int SIZE_RMT       = 32;
    localparam int SIZE_RMT_LOG   = 5;
    localparam int AMT_WALK_WIDTH = 4;
    localparam int AMT_DRAIN_MAX  = 7;

    typedef logic [1:0] rec_state_t;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_WALK  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/amt_recovery_sequencer.sv
// Stalls commit, drains in-flight AMT writes, then walks the AMT into the RMT under a ready handshake.
// Optional macro AMT_RECOVER_PERF_EN adds the recoverCycles_o busy-cycle counter.
module amt_recovery_sequencer
    import amt_recovery_sequencer_pkg::*;
#(
    parameter int NUM_LOG_REGS = SIZE_RMT,
    parameter int LOG_REG_W    = SIZE_RMT_LOG,
    parameter int WALK_WIDTH   = AMT_WALK_WIDTH,
    parameter int DRAIN_MAX    = AMT_DRAIN_MAX
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 recoverReq_i,
    input  logic                 commitBusy_i,
    input  logic                 rmtReady_i,
    output logic                 commitStall_o,
    output logic                 recoverValid_o,
    output logic [LOG_REG_W-1:0] amtBase_o,
    output logic                 recoverLast_o,
    output logic                 recoverDone_o,
    output logic                 recoverBusy_o
`ifdef AMT_RECOVER_PERF_EN
    ,
    output logic [15:0]          recoverCycles_o
`endif
);

    localparam logic [LOG_REG_W-1:0] WALK_STEP  = LOG_REG_W'(WALK_WIDTH);
    localparam logic [LOG_REG_W-1:0] LAST_BASE  = LOG_REG_W'(NUM_LOG_REGS - WALK_WIDTH);
    localparam logic [2:0]           DRAIN_LAST = 3'(DRAIN_MAX - 1);

    if ((NUM_LOG_REGS % WALK_WIDTH) != 0) begin : g_chk_walk
        $error("NUM_LOG_REGS must be a multiple of WALK_WIDTH");
    end
    if ((2 ** LOG_REG_W) != NUM_LOG_REGS) begin : g_chk_log
        $error("LOG_REG_W must equal log2(NUM_LOG_REGS)");
    end
    if ((DRAIN_MAX < 1) || (DRAIN_MAX > 7)) begin : g_chk_drain
        $error("DRAIN_MAX must fit in 3 bits and be nonzero");
    end

    rec_state_t     state;
    rec_state_t     state_nxt;
    logic [2:0]     drain_cnt;
    logic           beat_accept;
    logic           drain_timeout;

    assign commitStall_o  = (state != ST_IDLE);
    assign recoverBusy_o  = (state != ST_IDLE);
    assign recoverValid_o = (state == ST_WALK);
    assign recoverDone_o  = (state == ST_DONE);
    assign recoverLast_o  = (state == ST_WALK) && (amtBase_o == LAST_BASE);
    assign beat_accept    = recoverValid_o & rmtReady_i;

    // High on the cycle DRAIN gives up waiting: a commit write is still in flight and will be lost.
    assign drain_timeout  = (state == ST_DRAIN) && commitBusy_i && (drain_cnt == DRAIN_LAST);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (recoverReq_i) state_nxt = ST_DRAIN;
            ST_DRAIN: if (!commitBusy_i || drain_timeout) state_nxt = ST_WALK;
            ST_WALK:  if (beat_accept && recoverLast_o) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            drain_cnt <= '0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= (state == ST_DRAIN) ? drain_cnt + 3'd1 : 3'd0;
        end
    end

    // Base wraps to zero naturally after the last beat since the table size is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            amtBase_o <= '0;
        end else if (beat_accept) begin
            amtBase_o <= amtBase_o + WALK_STEP;
        end
    end

`ifdef AMT_RECOVER_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            recoverCycles_o <= '0;
        end else if (recoverBusy_o && (recoverCycles_o != 16'hFFFF)) begin
            recoverCycles_o <= recoverCycles_o + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_amt_recovery_sequencer.sv
// Directed self-checking bench for amt_recovery_sequencer; perf counter checks need AMT_RECOVER_PERF_EN.
module tb_amt_recovery_sequencer;

    logic       clk;
    logic       reset;
    logic       recoverReq_i;
    logic       commitBusy_i;
    logic       rmtReady_i;
    logic       commitStall_o;
    logic       recoverValid_o;
    logic [4:0] amtBase_o;
    logic       recoverLast_o;
    logic       recoverDone_o;
    logic       recoverBusy_o;
`ifdef AMT_RECOVER_PERF_EN
    logic [15:0] recoverCycles_o;
`endif

    int n_cmp = 0;
    int n_mis = 0;

    amt_recovery_sequencer dut (
        .clk            (clk),
        .reset          (reset),
        .recoverReq_i   (recoverReq_i),
        .commitBusy_i   (commitBusy_i),
        .rmtReady_i     (rmtReady_i),
        .commitStall_o  (commitStall_o),
        .recoverValid_o (recoverValid_o),
        .amtBase_o      (amtBase_o),
        .recoverLast_o  (recoverLast_o),
        .recoverDone_o  (recoverDone_o),
        .recoverBusy_o  (recoverBusy_o)
`ifdef AMT_RECOVER_PERF_EN
        ,
        .recoverCycles_o (recoverCycles_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        reset = 1'b1;
        recoverReq_i = 1'b0;
        commitBusy_i = 1'b0;
        rmtReady_i   = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if (commitStall_o !== 1'b0) begin n_mis++; $display("FAIL reset_stall: got %b expected 0", commitStall_o); end
        n_cmp++; if (recoverValid_o !== 1'b0) begin n_mis++; $display("FAIL reset_valid: got %b expected 0", recoverValid_o); end
        n_cmp++; if (amtBase_o !== 5'd0) begin n_mis++; $display("FAIL reset_base: got %0d expected 0", amtBase_o); end
        n_cmp++; if (recoverLast_o !== 1'b0) begin n_mis++; $display("FAIL reset_last: got %b expected 0", recoverLast_o); end
        n_cmp++; if (recoverDone_o !== 1'b0) begin n_mis++; $display("FAIL reset_done: got %b expected 0", recoverDone_o); end
        n_cmp++; if (recoverBusy_o !== 1'b0) begin n_mis++; $display("FAIL reset_busy: got %b expected 0", recoverBusy_o); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_full_walk();
        int cyc, beats;
        logic [4:0] exp_base;
        bit done_seen;
        rmtReady_i = 1'b1; commitBusy_i = 1'b0; recoverReq_i = 1'b1;
        @(negedge clk);
        recoverReq_i = 1'b0;
        n_cmp++; if (commitStall_o !== 1'b1 || recoverBusy_o !== 1'b1) begin n_mis++; $display("FAIL walk_stall_busy: got %b%b expected 11", commitStall_o, recoverBusy_o); end
        cyc = 0; beats = 0; exp_base = 5'd0; done_seen = 1'b0;
        for (int i = 0; i < 40 && !done_seen; i++) begin
            cyc++;
            if (recoverValid_o) begin
                n_cmp++; if (amtBase_o !== exp_base) begin n_mis++; $display("FAIL walk_base: got %0d expected %0d", amtBase_o, exp_base); end
                n_cmp++; if (recoverLast_o !== (exp_base == 5'd28)) begin n_mis++; $display("FAIL walk_last: got %b at base %0d", recoverLast_o, exp_base); end
                exp_base += 5'd4;
                beats++;
            end
            if (recoverDone_o) done_seen = 1'b1;
            else @(negedge clk);
        end
        n_cmp++; if (!done_seen) begin n_mis++; $display("FAIL walk_done_timeout: got no done expected done"); end
        n_cmp++; if (cyc != 10) begin n_mis++; $display("FAIL walk_latency: got %0d expected 10", cyc); end
        n_cmp++; if (beats != 8) begin n_mis++; $display("FAIL walk_beats: got %0d expected 8", beats); end
        n_cmp++; if (amtBase_o !== 5'd0 || recoverValid_o !== 1'b0 || commitStall_o !== 1'b1) begin n_mis++; $display("FAIL walk_done_state: got base %0d valid %b stall %b expected 0 0 1", amtBase_o, recoverValid_o, commitStall_o); end
        @(negedge clk);
        n_cmp++; if (commitStall_o !== 1'b0 || recoverBusy_o !== 1'b0 || recoverDone_o !== 1'b0) begin n_mis++; $display("FAIL walk_idle: got stall %b busy %b done %b expected 000", commitStall_o, recoverBusy_o, recoverDone_o); end
    endtask

    task automatic test_drain();
        int dc;
        bit to_seen;
        rmtReady_i = 1'b1; commitBusy_i = 1'b1; recoverReq_i = 1'b1;
        @(negedge clk);
        recoverReq_i = 1'b0;
        dc = 0; to_seen = 1'b0;
        for (int i = 0; i < 20 && !recoverValid_o; i++) begin
            dc++;
            to_seen |= dut.drain_timeout;
            if (dc == 3) commitBusy_i = 1'b0;
            @(negedge clk);
        end
        n_cmp++; if (dc != 3) begin n_mis++; $display("FAIL drain_len: got %0d expected 3", dc); end
        n_cmp++; if (to_seen !== 1'b0) begin n_mis++; $display("FAIL drain_no_error: got %b expected 0", to_seen); end
        n_cmp++; if (recoverValid_o !== 1'b1 || amtBase_o !== 5'd0) begin n_mis++; $display("FAIL drain_walk_start: got valid %b base %0d expected 1 0", recoverValid_o, amtBase_o); end
        for (int i = 0; i < 30 && !recoverDone_o; i++) @(negedge clk);
        n_cmp++; if (recoverDone_o !== 1'b1) begin n_mis++; $display("FAIL drain_done: got %b expected 1", recoverDone_o); end
        @(negedge clk);
    endtask

    task automatic test_drain_timeout();
        int dc, fire_at;
        rmtReady_i = 1'b1; commitBusy_i = 1'b1; recoverReq_i = 1'b1;
        @(negedge clk);
        recoverReq_i = 1'b0;
        dc = 0; fire_at = 0;
        for (int i = 0; i < 20 && !recoverValid_o; i++) begin
            dc++;
            if (dut.drain_timeout === 1'b1 && fire_at == 0) fire_at = dc;
            @(negedge clk);
        end
        n_cmp++; if (dc != 7) begin n_mis++; $display("FAIL timeout_len: got %0d expected 7", dc); end
        n_cmp++; if (fire_at != 7) begin n_mis++; $display("FAIL timeout_error_cycle: got %0d expected 7", fire_at); end
        commitBusy_i = 1'b0;
        for (int i = 0; i < 30 && !recoverDone_o; i++) @(negedge clk);
        n_cmp++; if (recoverDone_o !== 1'b1) begin n_mis++; $display("FAIL timeout_done: got %b expected 1", recoverDone_o); end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        logic [3:0] pat;
        logic [4:0] exp_base;
        int k, beats;
        pat = 4'b1001;
        rmtReady_i = 1'b1; commitBusy_i = 1'b0; recoverReq_i = 1'b1;
        @(negedge clk);
        recoverReq_i = 1'b0;
        k = 0; beats = 0; exp_base = 5'd0;
        for (int i = 0; i < 80 && !recoverDone_o; i++) begin
            if (recoverValid_o) begin
                n_cmp++; if (amtBase_o !== exp_base) begin n_mis++; $display("FAIL bp_base: got %0d expected %0d", amtBase_o, exp_base); end
                rmtReady_i = pat[k % 4];
                k++;
                if (rmtReady_i) begin exp_base += 5'd4; beats++; end
            end
            @(negedge clk);
        end
        n_cmp++; if (recoverDone_o !== 1'b1) begin n_mis++; $display("FAIL bp_done: got %b expected 1", recoverDone_o); end
        n_cmp++; if (beats != 8) begin n_mis++; $display("FAIL bp_beats: got %0d expected 8", beats); end
        n_cmp++; if (k != 16) begin n_mis++; $display("FAIL bp_walk_cycles: got %0d expected 16", k); end
        rmtReady_i = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_ignore_req();
        int beats, dones;
        rmtReady_i = 1'b1; commitBusy_i = 1'b0; recoverReq_i = 1'b1;
        @(negedge clk);
        recoverReq_i = 1'b0;
        beats = 0; dones = 0;
        for (int i = 0; i < 30; i++) begin
            recoverReq_i = 1'b0;
            if (recoverValid_o && rmtReady_i) begin
                beats++;
                if (beats == 4) recoverReq_i = 1'b1;
            end
            if (recoverDone_o) begin
                dones++;
                recoverReq_i = 1'b1;
            end
            @(negedge clk);
        end
        recoverReq_i = 1'b0;
        n_cmp++; if (dones != 1) begin n_mis++; $display("FAIL ignore_done_count: got %0d expected 1", dones); end
        n_cmp++; if (beats != 8) begin n_mis++; $display("FAIL ignore_beats: got %0d expected 8", beats); end
        n_cmp++; if (recoverBusy_o !== 1'b0 || commitStall_o !== 1'b0) begin n_mis++; $display("FAIL ignore_idle: got busy %b stall %b expected 0 0", recoverBusy_o, commitStall_o); end
    endtask

    task automatic test_async_reset();
        int beats;
        rmtReady_i = 1'b1; commitBusy_i = 1'b0; recoverReq_i = 1'b1;
        @(negedge clk);
        recoverReq_i = 1'b0;
        for (int i = 0; i < 20 && !(recoverValid_o && amtBase_o == 5'd12); i++) @(negedge clk);
        n_cmp++; if (recoverValid_o !== 1'b1 || amtBase_o !== 5'd12) begin n_mis++; $display("FAIL areset_reach_beat4: got valid %b base %0d expected 1 12", recoverValid_o, amtBase_o); end
        #1 reset = 1'b1;
        #1;
        n_cmp++; if ({commitStall_o, recoverValid_o, recoverLast_o, recoverDone_o, recoverBusy_o} !== 5'b0) begin n_mis++; $display("FAIL areset_outputs: got %b expected 00000", {commitStall_o, recoverValid_o, recoverLast_o, recoverDone_o, recoverBusy_o}); end
        n_cmp++; if (amtBase_o !== 5'd0) begin n_mis++; $display("FAIL areset_base: got %0d expected 0", amtBase_o); end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        recoverReq_i = 1'b1;
        @(negedge clk);
        recoverReq_i = 1'b0;
        for (int i = 0; i < 20 && !recoverValid_o; i++) @(negedge clk);
        n_cmp++; if (recoverValid_o !== 1'b1 || amtBase_o !== 5'd0) begin n_mis++; $display("FAIL areset_restart_base: got valid %b base %0d expected 1 0", recoverValid_o, amtBase_o); end
        beats = 0;
        for (int i = 0; i < 30 && !recoverDone_o; i++) begin
            if (recoverValid_o && rmtReady_i) beats++;
            @(negedge clk);
        end
        n_cmp++; if (beats != 8) begin n_mis++; $display("FAIL areset_restart_beats: got %0d expected 8", beats); end
        @(negedge clk);
    endtask

`ifdef AMT_RECOVER_PERF_EN
    task automatic test_perf();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_cmp++; if (recoverCycles_o !== 16'd0) begin n_mis++; $display("FAIL perf_reset: got %0d expected 0", recoverCycles_o); end
        rmtReady_i = 1'b1; commitBusy_i = 1'b0; recoverReq_i = 1'b1;
        @(negedge clk);
        recoverReq_i = 1'b0;
        for (int i = 0; i < 40 && !recoverDone_o; i++) @(negedge clk);
        n_cmp++; if (recoverDone_o !== 1'b1) begin n_mis++; $display("FAIL perf_done1: got %b expected 1", recoverDone_o); end
        @(negedge clk);
        recoverReq_i = 1'b1;
        @(negedge clk);
        recoverReq_i = 1'b0;
        for (int i = 0; i < 40 && !recoverDone_o; i++) @(negedge clk);
        n_cmp++; if (recoverDone_o !== 1'b1) begin n_mis++; $display("FAIL perf_done2: got %b expected 1", recoverDone_o); end
        @(negedge clk);
        n_cmp++; if (recoverCycles_o !== 16'd20) begin n_mis++; $display("FAIL perf_count: got %0d expected 20", recoverCycles_o); end
    endtask
`endif

    initial begin
        reset = 1'b1;
        recoverReq_i = 1'b0;
        commitBusy_i = 1'b0;
        rmtReady_i = 1'b0;
        test_reset();
        test_full_walk();
        test_drain();
        test_drain_timeout();
        test_backpressure();
        test_ignore_req();
        test_async_reset();
`ifdef AMT_RECOVER_PERF_EN
        test_perf();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
